// File: rtl/gemm_requant.sv
// gemm_requant: wide GEMM accumulators -> per-channel requantized int8 beats.
// Define GEMM_REQUANT_RELU_EN to clamp negative results to zero.
module gemm_requant #(
  parameter int LANES  = 8,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 16,
  parameter int MAX_CH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Control_start,
  input  logic [15:0]            Requant_OutFeature_Channel,
  input  logic [15:0]            Requant_OutMatrix_Row,
  input  logic                   s_axis_param_tvalid,
  output logic                   s_axis_param_tready,
  input  logic [63:0]            s_axis_param_tdata,
  input  logic                   s_axis_acc_tvalid,
  output logic                   s_axis_acc_tready,
  input  logic [LANES*ACC_W-1:0] s_axis_acc_tdata,
  output logic                   m_axis_q_tvalid,
  input  logic                   m_axis_q_tready,
  output logic [LANES*8-1:0]     m_axis_q_tdata,
  output logic                   m_axis_q_tlast,
  output logic                   busy,
  output logic                   done
);
  localparam int AW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int SW = ACC_W + 1;
  localparam int PW = SW + 16;
  localparam logic [15:0] LN = 16'(LANES);
  localparam logic [PW-1:0] HALF =
    {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [PW-1:0] QMAX =
    {{(PW-7){1'b0}}, 7'h7f};
  localparam logic signed [PW-1:0] QMIN =
    {{(PW-7){1'b1}}, 7'h00};

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [15:0] c_q, c_d, r_q, r_d;
  logic [15:0] ch_q, ch_d, cb_q, cb_d;
  logic [15:0] row_q, row_d;
  logic busy_q, busy_d, done_q, done_d;

  logic signed [15:0] scale_mem [MAX_CH];
  logic signed [31:0] bias_mem  [MAX_CH];

  logic v1_q, v2_q, v3_q;
  logic l1_q, l2_q, l3_q;
  logic signed [ACC_W-1:0] acc1_q [LANES];
  logic signed [15:0]      sc1_q  [LANES];
  logic signed [31:0]      bi1_q  [LANES];
  logic signed [SW-1:0]    s_c    [LANES];
  logic signed [PW-1:0]    p_c    [LANES];
  logic signed [PW-1:0]    p2_q   [LANES];
  logic signed [PW-1:0]    rnd_c  [LANES];
  logic signed [PW-1:0]    q_c    [LANES];
  logic [LANES*8-1:0] q3_q, q3_d;

  logic adv, p_fire, a_fire, a_last;
  logic unused_hi;

  assign unused_hi = ^s_axis_param_tdata[63:48];

  // Stall-all: every stage moves only when the output slot frees up
  assign adv = m_axis_q_tready | ~v3_q;
  assign s_axis_param_tready = (state_q == LOAD);
  assign s_axis_acc_tready = (state_q == RUN) & adv;
  assign p_fire = s_axis_param_tready & s_axis_param_tvalid;
  assign a_fire = s_axis_acc_tready & s_axis_acc_tvalid;
  assign a_last = (row_q == r_q - 16'd1) &&
                  (cb_q == c_q - LN);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    ch_d    = ch_q;
    cb_d    = cb_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Control_start) begin
          c_d    = Requant_OutFeature_Channel;
          r_d    = Requant_OutMatrix_Row;
          ch_d   = '0;
          cb_d   = '0;
          row_d  = '0;
          busy_d = 1'b1;
          if (Requant_OutFeature_Channel == '0 ||
              Requant_OutMatrix_Row == '0)
            state_d = DRAIN;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (p_fire) begin
          ch_d = ch_q + 16'd1;
          if (ch_q == c_q - 16'd1) state_d = RUN;
        end
      end
      RUN: begin
        if (a_fire) begin
          if (cb_q + LN == c_q) begin
            cb_d  = '0;
            row_d = row_q + 16'd1;
          end else begin
            cb_d = cb_q + LN;
          end
          if (a_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!v1_q && !v2_q &&
            (!v3_q || m_axis_q_tready)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      r_q     <= '0;
      ch_q    <= '0;
      cb_q    <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      ch_q    <= ch_d;
      cb_q    <= cb_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    q3_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s_c[i] = $signed({acc1_q[i][ACC_W-1], acc1_q[i]}) +
               $signed({{(SW-32){bi1_q[i][31]}}, bi1_q[i]});
      p_c[i] = $signed({{(PW-SW){s_c[i][SW-1]}}, s_c[i]}) *
               $signed({{(PW-16){sc1_q[i][15]}}, sc1_q[i]});
      rnd_c[i] = p2_q[i] + $signed(HALF);
      q_c[i] = rnd_c[i] >>> SHIFT;
`ifdef GEMM_REQUANT_RELU_EN
      if (q_c[i][PW-1]) q_c[i] = '0;
`endif
      if (q_c[i] > QMAX) q_c[i] = QMAX;
      if (q_c[i] < QMIN) q_c[i] = QMIN;
      q3_d[i*8 +: 8] = q_c[i][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
      l3_q <= 1'b0;
      q3_q <= '0;
    end else if (adv) begin
      v1_q <= a_fire;
      l1_q <= a_fire & a_last;
      v2_q <= v1_q;
      l2_q <= l1_q;
      v3_q <= v2_q;
      l3_q <= l2_q;
      q3_q <= v2_q ? q3_d : '0;
    end
  end

  // Table and datapath carry no reset; the table is rewritten every LOAD
  always_ff @(posedge clk) begin
    if (p_fire) begin
      scale_mem[ch_q[AW-1:0]] <= s_axis_param_tdata[47:32];
      bias_mem[ch_q[AW-1:0]]  <= s_axis_param_tdata[31:0];
    end
    if (adv) begin
      for (int i = 0; i < LANES; i++) begin
        acc1_q[i] <= s_axis_acc_tdata[i*ACC_W +: ACC_W];
        sc1_q[i]  <= scale_mem[cb_q[AW-1:0] + AW'(i)];
        bi1_q[i]  <= bias_mem[cb_q[AW-1:0] + AW'(i)];
        p2_q[i]   <= p_c[i];
      end
    end
  end

  assign m_axis_q_tvalid = v3_q;
  assign m_axis_q_tdata  = q3_q;
  assign m_axis_q_tlast  = l3_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule

// File: tb/tb_gemm_requant.sv
// tb_gemm_requant: random and directed runs against a behavioural requant model.
// Honours GEMM_REQUANT_RELU_EN in the reference model.
module tb_gemm_requant;
  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int SHIFT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] cfg_c = '0, cfg_r = '0;
  logic p_valid = 1'b0, p_ready;
  logic [63:0] p_data = '0;
  logic a_valid = 1'b0, a_ready;
  logic [LANES*ACC_W-1:0] a_data = '0;
  logic m_valid, m_ready = 1'b0, m_last;
  logic [LANES*8-1:0] m_data;
  logic busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int sc_t [256];
  int bi_t [256];
  logic [LANES*ACC_W-1:0] beats [$];
  logic [LANES*8-1:0] expq [$];

  always #5 clk = ~clk;

  gemm_requant dut (
    .clk                        (clk),
    .reset                      (reset),
    .Control_start              (start),
    .Requant_OutFeature_Channel (cfg_c),
    .Requant_OutMatrix_Row      (cfg_r),
    .s_axis_param_tvalid        (p_valid),
    .s_axis_param_tready        (p_ready),
    .s_axis_param_tdata         (p_data),
    .s_axis_acc_tvalid          (a_valid),
    .s_axis_acc_tready          (a_ready),
    .s_axis_acc_tdata           (a_data),
    .m_axis_q_tvalid            (m_valid),
    .m_axis_q_tready            (m_ready),
    .m_axis_q_tdata             (m_data),
    .m_axis_q_tlast             (m_last),
    .busy                       (busy),
    .done                       (done)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic longint ref_q(input longint acc,
                                   input longint bias,
                                   input longint scale);
    longint q;
    q = ((acc + bias) * scale + (longint'(1) << (SHIFT - 1)))
        >>> SHIFT;
`ifdef GEMM_REQUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic logic [LANES*ACC_W-1:0] gen(input int mode,
                                                 input int n);
    logic [LANES*ACC_W-1:0] b;
    logic [ACC_W-1:0] rt [LANES];
    rt = '{32'h8000, 32'h7fff, 32'hffff8000, 32'h18000,
           32'hfffe8000, 32'h7fffffff, 32'h80000000, 32'h0};
    b = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        0: b[i*ACC_W +: ACC_W] = 32'((i - 3) * 65536);
        2: b[i*ACC_W +: ACC_W] = rt[(i + n) % LANES];
        3: b[i*ACC_W +: ACC_W] = '0;
        default: b[i*ACC_W +: ACC_W] = $urandom;
      endcase
    end
    return b;
  endfunction

  function automatic logic [LANES*8-1:0] model(
      input logic [LANES*ACC_W-1:0] b, input int ch0);
    logic [LANES*8-1:0] e;
    longint a;
    for (int i = 0; i < LANES; i++) begin
      a = longint'($signed(b[i*ACC_W +: ACC_W]));
      e[i*8 +: 8] = 8'(ref_q(a, bi_t[ch0 + i], sc_t[ch0 + i]));
    end
    return e;
  endfunction

  task automatic set_tables(input int mode);
    for (int c = 0; c < 256; c++) begin
      case (mode)
        0: begin sc_t[c] = 1; bi_t[c] = 0; end
        1: begin sc_t[c] = 1; bi_t[c] = c << 16; end
        default: begin
          sc_t[c] = int'($signed(16'($urandom)));
          bi_t[c] = int'($urandom);
        end
      endcase
    end
  endtask

  task automatic run_job(input int c, input int r, input int mode,
                         input int bp, input int abort_at);
    int total, pi, ai, oi, last_cyc, cyc;
    bit got_done, stalled, aborted;
    logic [LANES*8-1:0] held, e, kexp;
    logic held_last;
    kexp = {8'h04, 8'h03, 8'h02, 8'h01,
            8'h00, 8'hff, 8'hfe, 8'hfd};
    total = r * c / LANES;
    beats.delete();
    expq.delete();
    for (int n = 0; n < total; n++) beats.push_back(gen(mode, n));
    @(negedge clk);
    cfg_c = 16'(c);
    cfg_r = 16'(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", busy, 1);
    pi = 0; ai = 0; oi = 0; cyc = 0;
    last_cyc = (total == 0) ? 0 : -10;
    got_done = 0; stalled = 0; aborted = 0;
    held = '0; held_last = 1'b0;
    while (cyc < 4000 && !got_done && !aborted) begin
      m_ready = bp ? (cyc % 3 == 0) : 1'b1;
      p_valid = (pi < c);
      p_data = {16'h0, 16'(sc_t[pi % 256]), 32'(bi_t[pi % 256])};
      a_valid = (ai < total);
      a_data = (ai < total) ? beats[ai] : '0;
      #1;
      if (done) begin
        check("done_cycle", cyc, last_cyc + 1);
        check("busy_at_done", busy, 0);
        got_done = 1;
      end
      if (stalled) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
        check("hold_last", m_last, held_last);
      end
      if (m_valid && !m_ready) check("acc_rdy_stall", a_ready, 0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("extra_beat", oi, total);
        end else begin
          e = expq.pop_front();
          check("beat_data", m_data, e);
          if (mode == 0) check("k_lanes", m_data, kexp);
        end
        check("beat_last", m_last, (oi == total - 1));
        oi++;
        if (oi == total) last_cyc = cyc;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      held_last = m_last;
      if (p_valid && p_ready) pi++;
      if (a_valid && a_ready) begin
        expq.push_back(model(beats[ai], (ai * LANES) % c));
        ai++;
        if (ai == abort_at) aborted = 1;
      end
      @(negedge clk);
      cyc++;
    end
    p_valid = 1'b0;
    a_valid = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_acc_rdy", a_ready, 0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("no_done_abort", done, 0);
        check("no_valid_abort", m_valid, 0);
      end
    end else begin
      check("done_seen", got_done, 1);
      check("beat_count", oi, total);
      check("accepted", ai, total);
    end
  endtask

  initial begin
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("r_valid", m_valid, 0);
    check("r_data", m_data, 0);
    check("r_last", m_last, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_prdy", p_ready, 0);
    check("r_ardy", a_ready, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("start_in_rst", busy, 0);

    set_tables(0);
    run_job(16, 23, 0, 0, 0);
    run_job(16, 5, 2, 0, 0);
    set_tables(1);
    run_job(16, 3, 3, 0, 0);
    set_tables(0);
    run_job(16, 23, 0, 1, 0);
    run_job(0, 5, 0, 0, 0);
    run_job(16, 0, 0, 0, 0);
    set_tables(2);
    run_job(32, 7, 4, 1, 0);
    set_tables(0);
    run_job(16, 23, 0, 0, 10);
    set_tables(2);
    run_job(16, 4, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
